raytracer_pixel_engine: RTL



---
 rtl/raytracer_pixel_engine.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/raytracer_pixel_engine.sv
// Sequenced per-pixel ray engine: nearest-sphere search, diffuse shading over all lights, RGB out.
// Optional RT_HIT_INFO_EN adds hit_valid/hit_idx/hit_t outputs alongside rgb.
module raytracer_pixel_engine #(
    parameter int DATA_W        = 12,
    parameter int FRAC_W        = 4,
    parameter int COLOR_W       = 8,
    parameter int SPHERE_COUNT  = 4,
    parameter int LIGHT_COUNT   = 2,
    parameter int IMG_W         = 640,
    parameter int IMG_H         = 480,
    parameter int FOCAL         = 256,
    parameter int AMBIENT_SHIFT = 3,
    parameter int BG_R          = 0,
    parameter int BG_G          = 0,
    parameter int BG_B          = 32,
    localparam int SIW = (SPHERE_COUNT > 1) ? $clog2(SPHERE_COUNT) : 1,
    localparam int LIW = (LIGHT_COUNT > 1) ? $clog2(LIGHT_COUNT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      px_valid,
    output logic                      px_ready,
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    output logic signed [DATA_W-1:0]  ray_dx,
    output logic signed [DATA_W-1:0]  ray_dy,
    output logic signed [DATA_W-1:0]  ray_dz,
    output logic [SIW-1:0]            sph_idx,
    input  logic signed [DATA_W-1:0]  sph_cx,
    input  logic signed [DATA_W-1:0]  sph_cy,
    input  logic signed [DATA_W-1:0]  sph_cz,
    input  logic [COLOR_W-1:0]        sph_r,
    input  logic [COLOR_W-1:0]        sph_g,
    input  logic [COLOR_W-1:0]        sph_b,
    input  logic                      isect_hit,
    input  logic signed [DATA_W-1:0]  isect_t,
    output logic [LIW-1:0]            light_idx,
    input  logic signed [DATA_W-1:0]  light_x,
    input  logic signed [DATA_W-1:0]  light_y,
    input  logic signed [DATA_W-1:0]  light_z,
    input  logic [COLOR_W-1:0]        light_r,
    input  logic [COLOR_W-1:0]        light_g,
    input  logic [COLOR_W-1:0]        light_b,
    input  logic signed [DATA_W-1:0]  light_int,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLOR_W-1:0]        rgb_r,
    output logic [COLOR_W-1:0]        rgb_g,
    output logic [COLOR_W-1:0]        rgb_b
`ifdef RT_HIT_INFO_EN
    ,
    output logic                      hit_valid,
    output logic [SIW-1:0]            hit_idx,
    output logic signed [DATA_W-1:0]  hit_t
`endif
);
    localparam int XW = 2*DATA_W + 4;
    localparam int AW = COLOR_W + 2;
    localparam logic signed [XW-1:0] SMAX  = (XW'(1) <<< (DATA_W-1)) - XW'(1);
    localparam logic signed [XW-1:0] SMIN  = -SMAX - XW'(1);
    localparam logic signed [XW-1:0] F_ONE = XW'(1) <<< FRAC_W;

    typedef enum logic [2:0] {S_IDLE, S_SPHERE, S_HITPT, S_LIGHT, S_OUT} state_t;
    state_t r_state, w_next;

    logic signed [DATA_W-1:0] r_dx, r_dy, r_dz, r_best_t, r_cx, r_cy, r_cz;
    logic signed [DATA_W-1:0] r_hx, r_hy, r_hz, r_nx, r_ny, r_nz;
    logic [SIW-1:0]           r_sph_idx;
    logic [LIW-1:0]           r_light_idx;
    logic                     r_best_vld;
    logic [COLOR_W-1:0]       r_obj_r, r_obj_g, r_obj_b, r_rgb_r, r_rgb_g, r_rgb_b;
    logic [AW-1:0]            r_acc_r, r_acc_g, r_acc_b;
`ifdef RT_HIT_INFO_EN
    logic [SIW-1:0]           r_best_idx, r_hit_idx;
    logic                     r_hit_valid;
    logic signed [DATA_W-1:0] r_hit_t;
`endif

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SMAX) return SMAX[DATA_W-1:0];
        if (v < SMIN) return SMIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    // ((obj*lightc) >> COLOR_W) scaled by f, a Q.FRAC_W factor in [0,1]
    function automatic logic [COLOR_W:0] shade(input logic [COLOR_W-1:0] o,
                                               input logic [COLOR_W-1:0] c,
                                               input logic [FRAC_W:0] f);
        logic [2*COLOR_W-1:0]      p;
        logic [COLOR_W+FRAC_W:0]   q;
        p = {{COLOR_W{1'b0}}, o} * {{COLOR_W{1'b0}}, c};
        p = p >> COLOR_W;
        q = {{(FRAC_W+1){1'b0}}, p[COLOR_W-1:0]} * {{COLOR_W{1'b0}}, f};
        q = q >> FRAC_W;
        return q[COLOR_W:0];
    endfunction

    function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] a, input logic [COLOR_W:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {2'b00, b};
        return s[AW] ? {AW{1'b1}} : s[AW-1:0];
    endfunction

    function automatic logic [COLOR_W-1:0] clamp_out(input logic [AW-1:0] a);
        return (|a[AW-1:COLOR_W]) ? {COLOR_W{1'b1}} : a[COLOR_W-1:0];
    endfunction

    logic                     w_cand, w_take, w_sph_last, w_light_last, w_any_hit;
    logic signed [DATA_W-1:0] w_rdx, w_rdy, w_hx, w_hy, w_hz, w_nx, w_ny, w_nz;
    logic signed [DATA_W-1:0] w_lx, w_ly, w_lz, w_ndl;
    logic signed [XW-1:0]     w_dot, w_fi;
    logic [FRAC_W:0]          w_f;
    logic [AW-1:0]            w_acc_r, w_acc_g, w_acc_b;

    assign w_cand       = isect_hit && !isect_t[DATA_W-1] && (isect_t != '0);
    assign w_take       = w_cand && (!r_best_vld || (isect_t < r_best_t));
    assign w_sph_last   = (r_sph_idx == SIW'(SPHERE_COUNT-1));
    assign w_light_last = (r_light_idx == LIW'(LIGHT_COUNT-1));
    assign w_any_hit    = r_best_vld || w_cand;

    assign w_rdx = sat(XW'(signed'({1'b0, pixel_x})) - XW'(IMG_W/2));
    assign w_rdy = sat(XW'(IMG_H/2) - XW'(signed'({1'b0, pixel_y})));

    assign w_hx = sat((XW'(r_best_t) * XW'(r_dx)) >>> FRAC_W);
    assign w_hy = sat((XW'(r_best_t) * XW'(r_dy)) >>> FRAC_W);
    assign w_hz = sat((XW'(r_best_t) * XW'(r_dz)) >>> FRAC_W);
    assign w_nx = sat(XW'(w_hx) - XW'(r_cx));
    assign w_ny = sat(XW'(w_hy) - XW'(r_cy));
    assign w_nz = sat(XW'(w_hz) - XW'(r_cz));

    assign w_lx  = sat(XW'(light_x) - XW'(r_hx));
    assign w_ly  = sat(XW'(light_y) - XW'(r_hy));
    assign w_lz  = sat(XW'(light_z) - XW'(r_hz));
    assign w_dot = XW'(r_nx) * XW'(w_lx) + XW'(r_ny) * XW'(w_ly) + XW'(r_nz) * XW'(w_lz);
    assign w_ndl = sat(w_dot >>> FRAC_W);
    assign w_fi  = (XW'(w_ndl) * XW'(light_int)) >>> FRAC_W;

    always_comb begin
        w_f = '0;
        if (w_fi[XW-1] || (w_fi == '0)) w_f = '0;
        else if (w_fi >= F_ONE)         w_f = F_ONE[FRAC_W:0];
        else                            w_f = w_fi[FRAC_W:0];
    end

    assign w_acc_r = acc_add(r_acc_r, shade(r_obj_r, light_r, w_f));
    assign w_acc_g = acc_add(r_acc_g, shade(r_obj_g, light_g, w_f));
    assign w_acc_b = acc_add(r_acc_b, shade(r_obj_b, light_b, w_f));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (px_valid)    w_next = S_SPHERE;
            S_SPHERE: if (w_sph_last)  w_next = w_any_hit ? S_HITPT : S_OUT;
            S_HITPT:                   w_next = S_LIGHT;
            S_LIGHT:  if (w_light_last) w_next = S_OUT;
            S_OUT:    if (out_ready)   w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dx <= '0; r_dy <= '0; r_dz <= '0;
            r_sph_idx <= '0; r_light_idx <= '0;
            r_best_vld <= 1'b0; r_best_t <= '0;
            r_cx <= '0; r_cy <= '0; r_cz <= '0;
            r_hx <= '0; r_hy <= '0; r_hz <= '0;
            r_nx <= '0; r_ny <= '0; r_nz <= '0;
            r_obj_r <= '0; r_obj_g <= '0; r_obj_b <= '0;
            r_acc_r <= '0; r_acc_g <= '0; r_acc_b <= '0;
            r_rgb_r <= '0; r_rgb_g <= '0; r_rgb_b <= '0;
`ifdef RT_HIT_INFO_EN
            r_best_idx <= '0; r_hit_idx <= '0; r_hit_valid <= 1'b0; r_hit_t <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (px_valid) begin
                    r_dx <= w_rdx; r_dy <= w_rdy; r_dz <= sat(XW'(FOCAL));
                    r_sph_idx <= '0; r_light_idx <= '0; r_best_vld <= 1'b0;
                end
                S_SPHERE: begin
                    if (w_take) begin
                        r_best_vld <= 1'b1; r_best_t <= isect_t;
                        r_cx <= sph_cx; r_cy <= sph_cy; r_cz <= sph_cz;
                        r_obj_r <= sph_r; r_obj_g <= sph_g; r_obj_b <= sph_b;
`ifdef RT_HIT_INFO_EN
                        r_best_idx <= r_sph_idx;
`endif
                    end
                    r_sph_idx <= w_sph_last ? '0 : r_sph_idx + SIW'(1);
                    if (w_sph_last && !w_any_hit) begin
                        r_rgb_r <= COLOR_W'(BG_R); r_rgb_g <= COLOR_W'(BG_G); r_rgb_b <= COLOR_W'(BG_B);
`ifdef RT_HIT_INFO_EN
                        r_hit_valid <= 1'b0; r_hit_idx <= '0; r_hit_t <= '0;
`endif
                    end
                end
                S_HITPT: begin
                    r_hx <= w_hx; r_hy <= w_hy; r_hz <= w_hz;
                    r_nx <= w_nx; r_ny <= w_ny; r_nz <= w_nz;
                    r_acc_r <= AW'(r_obj_r >> AMBIENT_SHIFT);
                    r_acc_g <= AW'(r_obj_g >> AMBIENT_SHIFT);
                    r_acc_b <= AW'(r_obj_b >> AMBIENT_SHIFT);
                end
                S_LIGHT: begin
                    r_acc_r <= w_acc_r; r_acc_g <= w_acc_g; r_acc_b <= w_acc_b;
                    r_light_idx <= w_light_last ? '0 : r_light_idx + LIW'(1);
                    if (w_light_last) begin
                        r_rgb_r <= clamp_out(w_acc_r);
                        r_rgb_g <= clamp_out(w_acc_g);
                        r_rgb_b <= clamp_out(w_acc_b);
`ifdef RT_HIT_INFO_EN
                        r_hit_valid <= 1'b1; r_hit_idx <= r_best_idx; r_hit_t <= r_best_t;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign px_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign ray_dx = r_dx;
    assign ray_dy = r_dy;
    assign ray_dz = r_dz;
    assign sph_idx   = r_sph_idx;
    assign light_idx = r_light_idx;
    assign rgb_r = r_rgb_r;
    assign rgb_g = r_rgb_g;
    assign rgb_b = r_rgb_b;
`ifdef RT_HIT_INFO_EN
    assign hit_valid = r_hit_valid;
    assign hit_idx   = r_hit_idx;
    assign hit_t     = r_hit_t;
`endif
endmodule
